// File: rtl/add_sub_post_norm_if.sv
// Handshake and data bundle for the add/sub post-normalizer: upstream raw sum in,
// downstream normalized result out.
interface add_sub_post_norm_if #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned MANT_W = 23
);
    // Upstream raw-sum side
    logic              i_valid;
    logic              o_ready;
    logic              i_sign;
    logic [EXP_W-1:0]  i_exp;
    logic [MANT_W+1:0] i_mant;

    // Downstream normalized-result side
    logic              o_valid;
    logic              i_ready;
    logic              o_sign;
    logic [EXP_W-1:0]  o_exp;
    logic [MANT_W-1:0] o_mant;
    logic              o_zero;
    logic              o_overflow;
    logic              o_underflow;

    modport slave (
        input  i_valid, i_sign, i_exp, i_mant, i_ready,
        output o_ready, o_valid, o_sign, o_exp, o_mant, o_zero, o_overflow, o_underflow
    );

    modport master (
        output i_valid, i_sign, i_exp, i_mant, i_ready,
        input  o_ready, o_valid, o_sign, o_exp, o_mant, o_zero, o_overflow, o_underflow
    );
endinterface

// File: rtl/add_sub_post_norm.sv
// Post-normalization of a floating-point add/sub magnitude sum: handles carry-out with a
// single right shift, then left-shifts one bit per cycle until the hidden bit is set.
module add_sub_post_norm #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned MANT_W = 23
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    add_sub_post_norm_if.slave   bus
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    // A carry out of the largest finite exponent would land on the all-ones code.
    localparam logic [EXP_W-1:0] ExpOvf = {{(EXP_W-1){1'b1}}, 1'b0};
    localparam logic [EXP_W-1:0] ExpOne = EXP_W'(1);

    logic [1:0]        state_q, state_d;
    logic              sign_q, sign_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic [MANT_W:0]   mant_q, mant_d;
    logic              zero_q, zero_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic              carry;
    logic              hidden;

    assign carry  = bus.i_mant[MANT_W+1];
    assign hidden = mant_q[MANT_W];

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        mant_d  = mant_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;

        unique case (state_q)
            StIdle: begin
                if (bus.i_valid) begin
                    sign_d = bus.i_sign;
                    zero_d = 1'b0;
                    ovf_d  = 1'b0;
                    unf_d  = 1'b0;
                    if (bus.i_mant == '0) begin
                        exp_d   = '0;
                        mant_d  = '0;
                        zero_d  = 1'b1;
                        state_d = StDone;
                    end else if (carry && (bus.i_exp == ExpOvf)) begin
                        exp_d   = '1;
                        mant_d  = '0;
                        ovf_d   = 1'b1;
                        state_d = StDone;
                    end else if (carry) begin
                        // LSB is truncated, no rounding at this stage.
                        mant_d  = bus.i_mant[MANT_W+1:1];
                        exp_d   = bus.i_exp + ExpOne;
                        state_d = StShift;
                    end else begin
                        mant_d  = bus.i_mant[MANT_W:0];
                        exp_d   = bus.i_exp;
                        state_d = StShift;
                    end
                end
            end

            StShift: begin
                // Mantissa is nonzero here, so the loop terminates within MANT_W+1 passes.
                if (hidden) begin
                    state_d = StDone;
                end else if (exp_q <= ExpOne) begin
                    exp_d   = '0;
                    mant_d  = '0;
                    unf_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    mant_d = {mant_q[MANT_W-1:0], 1'b0};
                    exp_d  = exp_q - ExpOne;
                end
            end

            StDone: begin
                if (bus.i_ready) begin
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            mant_q  <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            mant_q  <= mant_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign bus.o_ready     = (state_q == StIdle);
    assign bus.o_valid     = (state_q == StDone);
    assign bus.o_sign      = sign_q;
    assign bus.o_exp       = exp_q;
    assign bus.o_mant      = mant_q[MANT_W-1:0];
    assign bus.o_zero      = zero_q;
    assign bus.o_overflow  = ovf_q;
    assign bus.o_underflow = unf_q;

endmodule

// File: tb/tb_add_sub_post_norm.sv
// Scoreboard bench for add_sub_post_norm: driver queues hand-computed results, a negedge
// monitor pops and compares them (including latency) whenever o_valid rises.
module tb_add_sub_post_norm;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MANT_W = 23;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    add_sub_post_norm_if #(.EXP_W(EXP_W), .MANT_W(MANT_W)) bus ();

    add_sub_post_norm #(.EXP_W(EXP_W), .MANT_W(MANT_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        string       name;
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
        logic        zero;
        logic        ovf;
        logic        unf;
        int          lat;
        int          hs;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: compare on every rising o_valid
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
        end else begin
            chk("valid_ready_exclusive", 32'(bus.o_valid & bus.o_ready), 32'd0);
            if (bus.o_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid got o_valid=1 expected no pending result");
                end else begin
                    cur = sb.pop_front();
                    chk({cur.name, ":sign"}, 32'(bus.o_sign), 32'(cur.sign));
                    chk({cur.name, ":exp"}, 32'(bus.o_exp), 32'(cur.exp));
                    chk({cur.name, ":mant"}, 32'(bus.o_mant), 32'(cur.mant));
                    chk({cur.name, ":zero"}, 32'(bus.o_zero), 32'(cur.zero));
                    chk({cur.name, ":ovf"}, 32'(bus.o_overflow), 32'(cur.ovf));
                    chk({cur.name, ":unf"}, 32'(bus.o_underflow), 32'(cur.unf));
                    chk({cur.name, ":latency"}, 32'(cyc - cur.hs), 32'(cur.lat));
                end
            end
            prev_valid <= bus.o_valid;
        end
    end

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send(input string name, input logic s, input logic [7:0] ex,
                        input logic [24:0] m, input bit push, input logic [7:0] e_exp,
                        input logic [22:0] e_mant, input logic z, input logic o,
                        input logic u, input int lat);
        exp_t e;
        int   w = 0;
        bus.i_valid = 1'b1;
        bus.i_sign  = s;
        bus.i_exp   = ex;
        bus.i_mant  = m;
        while (!bus.o_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!bus.o_ready) begin
            checks++;
            errors++;
            $display("FAIL %s:accept got o_ready=0 expected 1 within 50 cycles", name);
            bus.i_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (push) begin
            e.name = name; e.sign = s; e.exp = e_exp; e.mant = e_mant;
            e.zero = z; e.ovf = o; e.unf = u; e.lat = lat; e.hs = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.i_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int w = 0;
        while (sb.size() != 0 && w < 60) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s:drain got %0d results pending expected 0", name, sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got no finish expected finish before 100000");
        $fatal(1);
    end

    initial begin
        bus.i_valid = 1'b0;
        bus.i_sign  = 1'b0;
        bus.i_exp   = '0;
        bus.i_mant  = '0;
        bus.i_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst:o_ready", 32'(bus.o_ready), 32'd1);
        chk("rst:o_valid", 32'(bus.o_valid), 32'd0);
        chk("rst:o_sign", 32'(bus.o_sign), 32'd0);
        chk("rst:o_exp", 32'(bus.o_exp), 32'd0);
        chk("rst:o_mant", 32'(bus.o_mant), 32'd0);
        chk("rst:flags", 32'({bus.o_zero, bus.o_overflow, bus.o_underflow}), 32'd0);

        // Release at a negedge; the very next rising edge must accept
        rst_n = 1'b1;
        send("normalized", 1'b0, 8'h80, 25'h0C00000, 1, 8'h80, 23'h400000, 0, 0, 0, 2);
        drain("normalized");
        send("carry", 1'b1, 8'h7F, 25'h1800000, 1, 8'h80, 23'h400000, 0, 0, 0, 2);
        drain("carry");
        send("cancel", 1'b0, 8'h85, 25'h0000100, 1, 8'h76, 23'h000000, 0, 0, 0, 17);
        drain("cancel");
        send("underflow", 1'b1, 8'h02, 25'h0000001, 1, 8'h00, 23'h000000, 0, 0, 1, 3);
        drain("underflow");
        send("zero", 1'b1, 8'h55, 25'h0000000, 1, 8'h00, 23'h000000, 1, 0, 0, 1);
        drain("zero");
        send("shift2", 1'b0, 8'h10, 25'h0200000, 1, 8'h0E, 23'h000000, 0, 0, 0, 4);
        drain("shift2");
        send("carry_trunc", 1'b0, 8'h20, 25'h1000001, 1, 8'h21, 23'h000000, 0, 0, 0, 2);
        drain("carry_trunc");
        send("reach_exp1", 1'b1, 8'h03, 25'h0200000, 1, 8'h01, 23'h000000, 0, 0, 0, 4);
        drain("reach_exp1");
        send("exp1_unf", 1'b0, 8'h01, 25'h0400000, 1, 8'h00, 23'h000000, 0, 0, 1, 2);
        drain("exp1_unf");
        send("all_ones", 1'b0, 8'h7F, 25'h0FFFFFF, 1, 8'h7F, 23'h7FFFFF, 0, 0, 0, 2);
        drain("all_ones");
        send("max_no_carry", 1'b1, 8'hFE, 25'h0800000, 1, 8'hFE, 23'h000000, 0, 0, 0, 2);
        drain("max_no_carry");

        // Overflow held under backpressure while a new input is offered
        bus.i_ready = 1'b0;
        send("overflow", 1'b0, 8'hFE, 25'h1000000, 1, 8'hFF, 23'h000000, 0, 1, 0, 1);
        for (int i = 0; i < 5; i++) begin
            bus.i_valid = 1'b1;
            bus.i_sign  = 1'b1;
            bus.i_exp   = 8'h10;
            bus.i_mant  = 25'h0800000;
            @(negedge clk);
            chk("hold:o_valid", 32'(bus.o_valid), 32'd1);
            chk("hold:o_ready", 32'(bus.o_ready), 32'd0);
            chk("hold:o_sign", 32'(bus.o_sign), 32'd0);
            chk("hold:o_exp", 32'(bus.o_exp), 32'hFF);
            chk("hold:o_overflow", 32'(bus.o_overflow), 32'd1);
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        @(negedge clk);
        chk("release:o_valid", 32'(bus.o_valid), 32'd0);
        chk("release:o_ready", 32'(bus.o_ready), 32'd1);
        drain("overflow");

        // Reset in the middle of a long shift sequence
        send("aborted", 1'b1, 8'h85, 25'h0000100, 0, 8'h00, 23'h000000, 0, 0, 0, 0);
        repeat (5) @(negedge clk);
        chk("pre_abort:o_ready", 32'(bus.o_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort:o_ready", 32'(bus.o_ready), 32'd1);
        chk("abort:o_valid", 32'(bus.o_valid), 32'd0);
        chk("abort:o_sign", 32'(bus.o_sign), 32'd0);
        chk("abort:o_exp", 32'(bus.o_exp), 32'd0);
        chk("abort:o_mant", 32'(bus.o_mant), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        chk("post_abort:o_valid", 32'(bus.o_valid), 32'd0);
        send("after_abort", 1'b1, 8'h80, 25'h0C00000, 1, 8'h80, 23'h400000, 0, 0, 0, 2);
        drain("after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
